// File: rtl/timer_bank_if.sv
// timer_bank_if: bus bundle for timer_bank.
//   master modport (bus side / bench): drives the load and tick controls and
//   reads back the count, the flags and the combined interrupt.
//   slave modport (timer_bank): the reverse view.
// Signals:
//   i_cs        active-low chip select; low at a rising edge loads channel i_ch
//   i_ch        channel index for load and read-back
//   i_mode      mode of a load: 0 SINGLE_SHOT, 1 CONTINUOUS
//   i_value     start/reload value of a load
//   i_tick      shared count enable
//   i_ack       per-channel flag clear
//   i_casc      (TIMER_BANK_CASCADE_EN only) cascade bit latched on load
//   o_rdata     registered count of channel i_ch
//   o_irq_flags sticky per-channel expiry flags
//   o_irq       registered OR of o_irq_flags
//   o_busy_dbg  per-channel state (1 = COUNTING), for observation only
// Handshake: there is no valid/ready pair. A load is a single-cycle command
// qualified only by i_cs being low at the rising edge; it is always accepted
// (or silently dropped when i_ch is out of range), so no back-pressure exists.
interface timer_bank_if #(
  parameter int WIDTH = 16,
  parameter int N_CH  = 4
);
  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  logic              i_cs;
  logic [CH_W-1:0]   i_ch;
  logic              i_mode;
  logic [WIDTH-1:0]  i_value;
  logic              i_tick;
  logic [N_CH-1:0]   i_ack;
`ifdef TIMER_BANK_CASCADE_EN
  logic              i_casc;
`endif
  logic [WIDTH-1:0]  o_rdata;
  logic [N_CH-1:0]   o_irq_flags;
  logic              o_irq;
  logic [N_CH-1:0]   o_busy_dbg;

  modport master (
`ifdef TIMER_BANK_CASCADE_EN
    output i_casc,
`endif
    output i_cs, i_ch, i_mode, i_value, i_tick, i_ack,
    input  o_rdata, o_irq_flags, o_irq, o_busy_dbg
  );

  modport slave (
`ifdef TIMER_BANK_CASCADE_EN
    input  i_casc,
`endif
    input  i_cs, i_ch, i_mode, i_value, i_tick, i_ack,
    output o_rdata, o_irq_flags, o_irq, o_busy_dbg
  );
endinterface

// File: rtl/timer_bank.sv
// timer_bank: N_CH independent WIDTH-bit down-counters with sticky expiry flags.
// Ports:
//   i_clk    system clock, all state on the rising edge
//   i_reset  asynchronous, active-high reset
//   bus      timer_bank_if.slave (load controls, tick, ack, read-back, irqs)
// Optional feature macro: TIMER_BANK_CASCADE_EN. When defined, a channel k>0
// loaded with i_casc=1 decrements on the cycle channel k-1 expires instead of
// on i_tick. When undefined every channel counts on i_tick only.
module timer_bank #(
  parameter int WIDTH = 16,
  parameter int N_CH  = 4
) (
  input  logic        i_clk,
  input  logic        i_reset,
  timer_bank_if.slave bus
);
  localparam int   CH_W      = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam logic MODE_CONT = 1'b1;

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_COUNTING = 1'b1
  } ch_state_e;

  logic [WIDTH-1:0] count_q  [N_CH];
  logic [WIDTH-1:0] count_d  [N_CH];
  logic [WIDTH-1:0] reload_q [N_CH];
  logic [WIDTH-1:0] reload_d [N_CH];
  ch_state_e        state_q  [N_CH];
  ch_state_e        state_d  [N_CH];
  logic [N_CH-1:0]  mode_q, mode_d;
  logic [N_CH-1:0]  flags_q, flags_d;
  logic             irq_q, irq_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;
`ifdef TIMER_BANK_CASCADE_EN
  logic [N_CH-1:0]  casc_q, casc_d;
`endif

  logic [N_CH-1:0]  load_sel;
  logic [N_CH-1:0]  step_en;
  logic [N_CH-1:0]  expire;

  always_comb begin : next_state
    logic prev_exp;
    prev_exp = 1'b0;
    load_sel = '0;
    step_en  = '0;
    expire   = '0;
    mode_d   = mode_q;
    flags_d  = flags_q;
    irq_d    = irq_q;
    rdata_d  = '0;
`ifdef TIMER_BANK_CASCADE_EN
    casc_d   = casc_q;
`endif
    for (int k = 0; k < N_CH; k++) begin
      count_d[k]  = count_q[k];
      reload_d[k] = reload_q[k];
      state_d[k]  = state_q[k];
    end

    // Channels are walked in index order so a cascaded channel sees the
    // expiry of its lower neighbour in the same cycle (prev_exp).
    for (int k = 0; k < N_CH; k++) begin
      load_sel[k] = !bus.i_cs && (int'(bus.i_ch) == k);
`ifdef TIMER_BANK_CASCADE_EN
      step_en[k]  = (k != 0 && casc_q[k]) ? prev_exp : bus.i_tick;
`else
      step_en[k]  = bus.i_tick;
`endif
      // A load on the same cycle overrides the expiry and suppresses the flag.
      expire[k]   = !load_sel[k] && (state_q[k] == ST_COUNTING) &&
                    step_en[k] && (count_q[k] == WIDTH'(1));
      prev_exp    = expire[k];

      if (load_sel[k]) begin
        reload_d[k] = bus.i_value;
        count_d[k]  = bus.i_value;
        mode_d[k]   = bus.i_mode;
        state_d[k]  = (bus.i_value != '0) ? ST_COUNTING : ST_IDLE;
`ifdef TIMER_BANK_CASCADE_EN
        casc_d[k]   = bus.i_casc;
`endif
      end else if (state_q[k] == ST_COUNTING && step_en[k]) begin
        if (count_q[k] == WIDTH'(1)) begin
          if (mode_q[k] == MODE_CONT) begin
            count_d[k] = reload_q[k];
          end else begin
            count_d[k] = '0;
            state_d[k] = ST_IDLE;
          end
        end else begin
          count_d[k] = count_q[k] - WIDTH'(1);
        end
      end
    end

    // Set beats clear when both happen on the same cycle.
    flags_d = expire | (flags_q & ~bus.i_ack);
    irq_d   = |flags_q;
    if (int'(bus.i_ch) < N_CH) begin
      rdata_d = count_q[bus.i_ch];
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int k = 0; k < N_CH; k++) begin
        count_q[k]  <= '0;
        reload_q[k] <= '0;
        state_q[k]  <= ST_IDLE;
      end
      mode_q  <= {N_CH{MODE_CONT}};
      flags_q <= '0;
      irq_q   <= 1'b0;
      rdata_q <= '0;
`ifdef TIMER_BANK_CASCADE_EN
      casc_q  <= '0;
`endif
    end else begin
      for (int k = 0; k < N_CH; k++) begin
        count_q[k]  <= count_d[k];
        reload_q[k] <= reload_d[k];
        state_q[k]  <= state_d[k];
      end
      mode_q  <= mode_d;
      flags_q <= flags_d;
      irq_q   <= irq_d;
      rdata_q <= rdata_d;
`ifdef TIMER_BANK_CASCADE_EN
      casc_q  <= casc_d;
`endif
    end
  end

  always_comb begin
    bus.o_busy_dbg = '0;
    for (int k = 0; k < N_CH; k++) begin
      bus.o_busy_dbg[k] = (state_q[k] == ST_COUNTING);
    end
  end

  assign bus.o_rdata     = rdata_q;
  assign bus.o_irq_flags = flags_q;
  assign bus.o_irq       = irq_q;
endmodule
